// File: rtl/temp_alarm_monitor.sv
// temp_alarm_monitor
// Classifies sampled temperature codes into NORMAL / PREVEN / CRITICAL with
// entry thresholds, exit hysteresis, a persistence filter on level changes
// and an optional fast path into CRITICAL. All outputs are decoded from
// registered state; crit_latched is a sticky record of any CRITICAL entry.
module temp_alarm_monitor #(
    parameter int WIDTH        = 3,
    parameter int PREVEN_LEVEL = 4,
    parameter int CRIT_LEVEL   = 6,
    parameter int HYST         = 1,
    parameter int PERSIST      = 3,
    parameter int CRIT_FAST    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] temp_code,
    input  logic             clear_crit,
    output logic [1:0]       alarm_state,
    output logic             temp_preven,
    output logic             temp_crit,
    output logic             crit_latched,
    output logic             state_chg
);

    localparam logic [1:0] NORMAL   = 2'b00;
    localparam logic [1:0] PREVEN   = 2'b01;
    localparam logic [1:0] CRITICAL = 2'b10;

    // Persistence counter only ever needs to reach PERSIST before resetting.
    localparam int CW = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] PERSIST_CNT = CW'(PERSIST);

    // Thresholds carried in WIDTH+1 bits so the hysteresis subtraction can
    // never wrap for any legal parameter set.
    localparam logic [WIDTH:0] PREV_ENTER = (WIDTH+1)'(PREVEN_LEVEL);
    localparam logic [WIDTH:0] PREV_EXIT  = (WIDTH+1)'(PREVEN_LEVEL - HYST);
    localparam logic [WIDTH:0] CRIT_ENTER = (WIDTH+1)'(CRIT_LEVEL);
    localparam logic [WIDTH:0] CRIT_EXIT  = (WIDTH+1)'(CRIT_LEVEL - HYST);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [1:0]    pend_target;
    logic [1:0]    pend_next;
    logic [1:0]    target;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] run_len;
    logic [WIDTH:0] code;
    logic          fast_hit;

    assign code = {1'b0, temp_code};

    // Level the current sample argues for, given the level we are in now.
    always_comb begin
        target = state;
        case (state)
            NORMAL: begin
                if (code >= CRIT_ENTER)      target = CRITICAL;
                else if (code >= PREV_ENTER) target = PREVEN;
                else                         target = NORMAL;
            end
            PREVEN: begin
                if (code >= CRIT_ENTER)      target = CRITICAL;
                else if (code < PREV_EXIT)   target = NORMAL;
                else                         target = PREVEN;
            end
            CRITICAL: begin
                if (code >= CRIT_EXIT)       target = CRITICAL;
                else if (code < PREV_EXIT)   target = NORMAL;
                else                         target = PREVEN;
            end
            default: target = NORMAL;
        endcase
    end

    assign fast_hit = (CRIT_FAST != 0) && (target == CRITICAL);

    // Persistence filter: a change is committed once the same differing
    // target has been seen PERSIST valid samples in a row (idle cycles do
    // not break the run); a fast-critical sample bypasses the count.
    always_comb begin
        state_next = state;
        pend_next  = pend_target;
        count_next = count;
        run_len    = count;
        if (sample_valid) begin
            if (target == state) begin
                count_next = '0;
            end else begin
                if (target == pend_target) begin
                    run_len = count + 1'b1;
                end else begin
                    pend_next = target;
                    run_len   = CW'(1);
                end
                if (fast_hit || (run_len == PERSIST_CNT)) begin
                    state_next = target;
                    count_next = '0;
                end else begin
                    count_next = run_len;
                end
            end
        end
    end

    // State, filter bookkeeping, change pulse and the sticky critical flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= NORMAL;
            pend_target  <= NORMAL;
            count        <= '0;
            state_chg    <= 1'b0;
            crit_latched <= 1'b0;
        end else begin
            state       <= state_next;
            pend_target <= pend_next;
            count       <= count_next;
            state_chg   <= (state_next != state);
            if ((state_next == CRITICAL) && (state != CRITICAL))
                crit_latched <= 1'b1;
            else if (clear_crit && (state != CRITICAL))
                crit_latched <= 1'b0;
        end
    end

    assign alarm_state = state;
    assign temp_preven = (state == PREVEN);
    assign temp_crit   = (state == CRITICAL);

endmodule

// File: doc/temp_alarm_monitor.md
Name: temp_alarm_monitor

Overview:
Sequential successor to the single-code preventive-temperature decoder. It classifies a sampled temperature code into one of three levels: NORMAL, PREVEN (preventive) or CRITICAL. Thresholds, hysteresis, persistence filtering and a fast-critical mode are all parametrised. The block sits between the temperature sample source (switches or sensor interface) and the alarm/indicator logic.

Parameters:
WIDTH, 3, width of temp_code.
PREVEN_LEVEL, 4, entry threshold for PREVEN (temp_code >= PREVEN_LEVEL).
CRIT_LEVEL, 6, entry threshold for CRITICAL (temp_code >= CRIT_LEVEL).
HYST, 1, hysteresis; level N is left only when temp_code < N_LEVEL - HYST.
PERSIST, 3, consecutive valid samples required to change level (>= 1).
CRIT_FAST, 0, 1 = enter CRITICAL on a single qualifying sample.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  reset, synchronous, active-high
sample_valid  in  1  temp_code is a new sample this cycle
temp_code  in  WIDTH  sampled temperature code, unsigned
clear_crit  in  1  clears crit_latched (ignored while in CRITICAL)
alarm_state  out  2  00=NORMAL, 01=PREVEN, 10=CRITICAL (11 never produced)
temp_preven  out  1  1 iff alarm_state==PREVEN
temp_crit  out  1  1 iff alarm_state==CRITICAL
crit_latched  out  1  sticky: set on entry to CRITICAL
state_chg  out  1  one-cycle pulse on the cycle after any level change

Behaviour:
- Legal parameters: PREVEN_LEVEL < CRIT_LEVEL <= 2^WIDTH-1, HYST <= PREVEN_LEVEL, HYST < CRIT_LEVEL-PREVEN_LEVEL+1, PERSIST >= 1. Threshold arithmetic is unsigned in WIDTH+1 bits, so no underflow occurs.
- Reset (synchronous, overrides everything): state NORMAL, persistence counter 0, pend_target NORMAL, all outputs 0.
- Target level per valid sample, given the current state:
  - NORMAL: CRITICAL if code >= CRIT_LEVEL; else PREVEN if code >= PREVEN_LEVEL; else NORMAL.
  - PREVEN: CRITICAL if code >= CRIT_LEVEL; else NORMAL if code < PREVEN_LEVEL-HYST; else PREVEN.
  - CRITICAL: stay if code >= CRIT_LEVEL-HYST; else NORMAL if code < PREVEN_LEVEL-HYST; else PREVEN.
- Persistence counter, width clog2(PERSIST+1), updated only on sample_valid=1:
  - target==state: counter <= 0.
  - target!=state and target==pend_target: counter increments.
  - target differs from pend_target: pend_target <= target, counter <= 1.
  - When the new count equals PERSIST: state <= target and counter <= 0 on that same edge.
- CRIT_FAST=1: a valid sample whose target is CRITICAL moves the state to CRITICAL on that edge, regardless of the counter. Exits from CRITICAL still need PERSIST samples.
- sample_valid=0: counter, pend_target and state hold. Idle gaps do not break a consecutive run.
- Outputs are Moore-decoded from the state register. Level outputs change on the edge that accepts the qualifying sample and are visible the following cycle.
- state_chg is registered: high for exactly one cycle after each edge that changes state.
- crit_latched:
  - Set on the edge entering CRITICAL.
  - clear_crit=1 while state!=CRITICAL clears it on the next edge.
  - If entry to CRITICAL and clear_crit coincide, set wins.
- A direct jump NORMAL->CRITICAL or CRITICAL->NORMAL is permitted (single transition, single state_chg pulse).
- Reset mid-count discards all partial persistence.

Test Plan:
1. Defaults; reset, then samples 4,4,4 back-to-back -> temp_preven=1 after third sample edge, alarm_state=01, state_chg high exactly 1 cycle; first two samples leave outputs 0.
2. NORMAL, samples 4,4,3,4,4,4 -> no change through sample 5; PREVEN entered on sample 6 (the 3 cleared the run).
3. In PREVEN, samples 3,3,3 -> stays PREVEN (3 not < 3); then 2,2,2 -> NORMAL after the third 2, temp_preven=0, one state_chg pulse.
4. NORMAL: sample 7, 5 idle cycles, 7, 7 -> CRITICAL after third valid, temp_crit=1, crit_latched=1. Then clear_crit pulse -> latch stays 1. Then samples 4,4,4 -> PREVEN. Then clear_crit -> crit_latched=0 next cycle.
5. CRIT_FAST=1, NORMAL: single sample 6 -> alarm_state=10 next cycle. Same cycle clear_crit=1 -> crit_latched=1.
6. Samples 4,4, then reset asserted 1 cycle, then a single sample 4 -> outputs remain 0, alarm_state=00.
